mem_arbiter: RTL

Shares the single 8-bit system memory between two requesters, instruction fetch (port 0) and the load/store unit (port 1), inside `system`. Each requester issues 16-bit read or write transactions; the arbiter grants one port at a time round-robin and sequences each transaction as two byte accesses on the memory's address, write-enable and chip-select lines. The top level turns the separate memory write and read data paths into the memory's shared tristate bus.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 37 +++
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
//   arb_state_t : transaction sequencer states
//   PORT_IF     : index of the instruction-fetch requester
//   PORT_LSU    : index of the load/store requester
//   WORD_W      : requester transaction width
package mem_arb_pkg;

  localparam int WORD_W = 16;

  localparam logic [0:0] PORT_IF  = 1'b0;
  localparam logic [0:0] PORT_LSU = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    ACK  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i[1:0]   : request vector
//   update_i     : commit the current grant as the last-served port
//   gnt_o[1:0]   : one-hot grant (combinational from req_i and pointer)
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  // Index of the port served last; reset to 1 so port 0 wins the first tie.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_i && (gnt_o != 2'b00)) ptr_d = gnt_o[1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 1'b1;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide memory between instruction fetch (port 0)
// and the load/store unit (port 1). Each 16-bit transaction is sequenced as two
// big-endian byte accesses (A = high byte, A+1 = low byte).
//   clk, rst                 : clock, synchronous active-high reset
//   pN_req/we/addr/wdata     : requester N transaction (level req, held to ack)
//   pN_ack, pN_rdata         : one-cycle completion pulse, held read result
//   mem_addr/wdata/we/cs     : registered memory control and write byte
//   mem_rdata                : memory read byte, valid one cycle after address
//   busy                     : a transaction is in progress
// The memory data path is kept as separate write/read byte ports here;
// mem_we qualifies the cycles in which mem_wdata may drive the shared bus.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p0_req,
  input  logic                p1_req,
  input  logic                p0_we,
  input  logic                p1_we,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [2*DATA_W-1:0] p0_wdata,
  input  logic [2*DATA_W-1:0] p1_wdata,
  output logic                p0_ack,
  output logic                p1_ack,
  output logic [2*DATA_W-1:0] p0_rdata,
  output logic [2*DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_we,
  output logic                mem_cs,
  output logic                busy
);

  localparam int TW = 2 * DATA_W;

  arb_state_t state_q, state_d;

  // Transaction latched at arbitration time.
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;

  // Registered outputs.
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [TW-1:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic              mwe_q, mwe_d, mcs_q, mcs_d, busy_q, busy_d;

  logic [1:0] gnt;
  logic       arb_upd;

  rr_arbiter2 u_rr (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    ({p1_req, p0_req}),
    .update_i (arb_upd),
    .gnt_o    (gnt)
  );

  // State register (also holds every other registered value).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwe_q    <= 1'b0;
      mcs_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rbuf_q   <= rbuf_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwe_q    <= mwe_d;
      mcs_q    <= mcs_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and transaction latch.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    arb_upd = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          arb_upd = 1'b1;
          state_d = B0;
          port_d  = gnt[1];
          we_d    = gnt[1] ? p1_we    : p0_we;
          addr_d  = gnt[1] ? p1_addr  : p0_addr;
          wdata_d = gnt[1] ? p1_wdata : p0_wdata;
        end
      end
      B0:      state_d = B1;
      B1:      state_d = we_q ? ACK : B2;
      B2:      state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered
  // and the transaction fields being latched on the same edge.
  always_comb begin
    mcs_d    = 1'b0;
    mwe_d    = 1'b0;
    maddr_d  = '0;
    mwdata_d = '0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    busy_d   = (state_d != IDLE);
    rbuf_d   = rbuf_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_d)
      B0: begin
        mcs_d    = 1'b1;
        mwe_d    = we_d;
        maddr_d  = addr_d;
        mwdata_d = wdata_d[TW-1:DATA_W];
      end
      B1: begin
        mcs_d    = 1'b1;
        mwe_d    = we_d;
        maddr_d  = addr_d + ADDR_W'(1);   // wraps modulo 2^ADDR_W
        mwdata_d = wdata_d[DATA_W-1:0];
      end
      ACK: begin
        if (port_d == PORT_LSU) ack1_d = 1'b1;
        else                    ack0_d = 1'b1;
      end
      default: ;
    endcase
    // mem_rdata lags the address by one cycle: the high byte arrives while in
    // B1 and the low byte while in B2.
    if (state_q == B1 && !we_q) rbuf_d = mem_rdata;
    if (state_q == B2) begin
      if (port_q == PORT_LSU) rdata1_d = {rbuf_q, mem_rdata};
      else                    rdata0_d = {rbuf_q, mem_rdata};
    end
  end

  assign p0_ack    = ack0_q;
  assign p1_ack    = ack1_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign mem_we    = mwe_q;
  assign mem_cs    = mcs_q;
  assign busy      = busy_q;

endmodule
